// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic LVL_IDLE  = 1'b1;
    localparam logic LVL_START = 1'b0;
    localparam logic LVL_STOP  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, bit_tick marks the last cycle of a bit.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_tick,
    output logic tick_next_c
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Idle holds the count at zero, so the first bit after an accept is full length.
    always_comb begin
        cnt_next = '0;
        if (run && (cnt != CW'(CLKS_PER_BIT - 1))) begin
            cnt_next = cnt + CW'(1);
        end
        tick_next_c = run && (cnt_next == CW'(CLKS_PER_BIT - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            bit_tick <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            bit_tick <= tick_next_c;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, LSB-first data, optional even parity, stop bit; all outputs registered.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned WD           = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [WD-1:0] d,
    input  logic          valid,
    output logic          ready,
    output logic          q,
    output logic          busy,
    output logic          done
);

    localparam int unsigned IDX_W = (WD > 1) ? $clog2(WD) : 1;

    tx_state_e      state;
    tx_state_e      state_nxt;
    logic [WD-1:0]  shreg;
    logic [WD-1:0]  shreg_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic           par;
    logic           par_nxt;
    logic           q_nxt;
    logic           busy_nxt;
    logic           ready_nxt;
    logic           done_nxt;
    logic           bit_tick;
    logic           tick_next_c;
    logic           accept;
    logic           last_bit;

    assign accept   = ready && valid;
    assign last_bit = (idx == IDX_W'(WD - 1));

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (busy),
        .bit_tick   (bit_tick),
        .tick_next_c(tick_next_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept)   state_nxt = ST_START;
            ST_START:  if (bit_tick) state_nxt = ST_DATA;
            ST_DATA:   if (bit_tick && last_bit) state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_tick) state_nxt = ST_STOP;
            ST_STOP:   if (bit_tick) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next values of datapath and outputs, derived from the state we are about to enter.
    always_comb begin
        shreg_nxt = shreg;
        idx_nxt   = idx;
        par_nxt   = par;
        if (accept) begin
            shreg_nxt = d;
            idx_nxt   = '0;
            par_nxt   = ^d;
        end else if ((state == ST_DATA) && bit_tick) begin
            shreg_nxt = shreg >> 1;
            idx_nxt   = last_bit ? '0 : idx + IDX_W'(1);
        end

        case (state_nxt)
            ST_START:  q_nxt = LVL_START;
            ST_DATA:   q_nxt = shreg_nxt[0];
            ST_PARITY: q_nxt = par_nxt;
            ST_STOP:   q_nxt = LVL_STOP;
            default:   q_nxt = LVL_IDLE;
        endcase

        busy_nxt  = (state_nxt != ST_IDLE);
        ready_nxt = (state_nxt == ST_IDLE);
        done_nxt  = (state == ST_STOP) && tick_next_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            idx   <= '0;
            par   <= 1'b0;
            q     <= LVL_IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            shreg <= shreg_nxt;
            idx   <= idx_nxt;
            par   <= par_nxt;
            q     <= q_nxt;
            busy  <= busy_nxt;
            ready <= ready_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (parity on / parity off) against a frame-level model and a line receiver.
module tb_serial_tx;

    localparam int unsigned WD  = 8;
    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d;
    logic       valid;
    logic       ready0, q0, busy0, done0;
    logic       ready1, q1, busy1, done1;
    logic [1:0] rdy, qq, bsy, dn;

    int checks = 0;
    int errors = 0;

    assign rdy = {ready1, ready0};
    assign qq  = {q1, q0};
    assign bsy = {busy1, busy0};
    assign dn  = {done1, done0};

    serial_tx #(.WD(WD), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u_par (
        .clk(clk), .reset(reset), .d(d), .valid(valid),
        .ready(ready0), .q(q0), .busy(busy0), .done(done0)
    );

    serial_tx #(.WD(WD), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u_nopar (
        .clk(clk), .reset(reset), .d(d), .valid(valid),
        .ready(ready1), .q(q1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: list of expected line levels per cycle, built from the frame rules.
    int          m_len [2];
    int          m_pos [2];
    logic [63:0] m_bits [2];

    task automatic model_build(input int i, input logic [7:0] w);
        logic [11:0] frame;
        int nb;
        int n;
        nb = (i == 0) ? WD + 3 : WD + 2;
        frame = '1;
        frame[0] = 1'b0;
        for (int k = 0; k < WD; k++) frame[k+1] = w[k];
        if (i == 0) frame[WD+1] = ^w;
        frame[nb-1] = 1'b1;
        n = 0;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < CPB; k++) begin
                m_bits[i][n] = frame[b];
                n++;
            end
        end
        m_len[i] = n;
        m_pos[i] = 0;
    endtask

    initial begin
        m_len = '{0, 0};
        m_pos = '{0, 0};
        forever begin
            @(posedge clk or negedge reset);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    m_len[i] = 0;
                    m_pos[i] = 0;
                end else if (m_pos[i] < m_len[i]) begin
                    m_pos[i]++;
                end else if (valid) begin
                    model_build(i, d);
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    int done_cnt [2];
    initial begin
        done_cnt = '{0, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic inf;
                inf = (m_pos[i] < m_len[i]);
                chk($sformatf("q%0d", i),     32'(qq[i]),  32'(inf ? m_bits[i][m_pos[i]] : 1'b1));
                chk($sformatf("busy%0d", i),  32'(bsy[i]), 32'(inf));
                chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(!inf));
                chk($sformatf("done%0d", i),  32'(dn[i]),  32'(inf && (m_pos[i] == m_len[i] - 1)));
                if (dn[i]) done_cnt[i]++;
            end
        end
    end

    // Reference receiver: detects start, samples mid-bit, checks framing and parity.
    logic        rx_act [2];
    int          rx_cyc [2];
    logic [11:0] rx_bits [2];
    logic [7:0]  rx_log [2][16];
    int          rx_n [2];
    int          rx_rd [2];

    initial begin
        rx_act = '{1'b0, 1'b0};
        rx_cyc = '{0, 0};
        rx_n   = '{0, 0};
        rx_rd  = '{0, 0};
        forever begin
            @(negedge clk or negedge reset);
            for (int i = 0; i < 2; i++) begin
                int nb;
                nb = (i == 0) ? WD + 3 : WD + 2;
                if (!reset) begin
                    rx_act[i] = 1'b0;
                end else begin
                    if (!rx_act[i] && (qq[i] == 1'b0)) begin
                        rx_act[i] = 1'b1;
                        rx_cyc[i] = 0;
                        rx_bits[i] = '0;
                    end
                    if (rx_act[i]) begin
                        if ((rx_cyc[i] % CPB) == CPB / 2) rx_bits[i][rx_cyc[i] / CPB] = qq[i];
                        if (rx_cyc[i] == nb * CPB - 1) begin
                            chk($sformatf("rx%0d_start", i), 32'(rx_bits[i][0]), 32'(1'b0));
                            chk($sformatf("rx%0d_stop", i), 32'(rx_bits[i][nb-1]), 32'(1'b1));
                            if (i == 0) chk("rx0_even_parity", 32'(^rx_bits[i][9:1]), 32'(1'b0));
                            if (rx_n[i] < 16) rx_log[i][rx_n[i]] = rx_bits[i][8:1];
                            rx_n[i]++;
                            rx_act[i] = 1'b0;
                        end else begin
                            rx_cyc[i]++;
                        end
                    end
                end
            end
        end
    end

    task automatic check_rx(input int i, input logic [7:0] w);
        chk($sformatf("rx%0d_avail", i), 32'(rx_n[i] > rx_rd[i]), 32'(1'b1));
        if (rx_rd[i] < rx_n[i] && rx_rd[i] < 16) begin
            chk($sformatf("rx%0d_word", i), 32'(rx_log[i][rx_rd[i]]), 32'(w));
            rx_rd[i]++;
        end
    endtask

    logic [1:0] rec_q [0:99];
    logic [1:0] rec_b [0:99];
    logic [1:0] rec_d [0:99];
    logic [1:0] rec_r [0:99];

    task automatic record(input int n, input bit toggle);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            rec_q[c] = qq;
            rec_b[c] = bsy;
            rec_d[c] = dn;
            rec_r[c] = rdy;
            if (toggle) begin
                d     = 8'($urandom);
                valid = (c < 36) ? 1'($urandom) : 1'b0;
            end
        end
    endtask

    function automatic int count_rec(input int i, input int n, input bit use_done);
        int s;
        s = 0;
        for (int c = 1; c <= n; c++) s += use_done ? int'(rec_d[c][i]) : int'(rec_b[c][i]);
        return s;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(ready0 && ready1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_in_budget", 32'(n < 200), 32'(1'b1));
    endtask

    task automatic start_frame(input logic [7:0] w);
        wait_idle();
        d     = w;
        valid = 1'b1;
        @(posedge clk);
        #2 valid = 1'b0;
    endtask

    logic [10:0] exp_a5;

    initial begin
        exp_a5 = 11'b10101001010;
        reset = 1'b1;
        d     = '0;
        valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("reset_q", 32'(q0), 32'(1'b1));
        chk("reset_ready", 32'(ready0), 32'(1'b1));
        chk("reset_busy", 32'(busy0), 32'(1'b0));
        chk("reset_done", 32'(done0), 32'(1'b0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        repeat (20) @(negedge clk);
        chk("idle_done_cnt0", 32'(done_cnt[0]), 32'(0));
        chk("idle_done_cnt1", 32'(done_cnt[1]), 32'(0));
        chk("idle_q", 32'(q0), 32'(1'b1));
        chk("idle_ready", 32'(ready0), 32'(1'b1));

        start_frame(8'hA5);
        record(46, 1'b0);
        for (int b = 0; b < 11; b++) chk($sformatf("a5_bit%0d", b), 32'(rec_q[b*CPB+2][0]), 32'(exp_a5[b]));
        chk("a5_first_cycle_start", 32'(rec_q[1][0]), 32'(1'b0));
        chk("a5_busy_cycles", 32'(count_rec(0, 46, 1'b0)), 32'(44));
        chk("a5_done_count", 32'(count_rec(0, 46, 1'b1)), 32'(1));
        chk("a5_done_cycle44", 32'(rec_d[44][0]), 32'(1'b1));
        chk("a5_ready_cycle45", 32'(rec_r[45][0]), 32'(1'b1));
        chk("a5_nopar_busy_cycles", 32'(count_rec(1, 46, 1'b0)), 32'(40));
        check_rx(0, 8'hA5);
        check_rx(1, 8'hA5);

        start_frame(8'h07);
        record(46, 1'b0);
        chk("p07_parity_bit", 32'(rec_q[9*CPB+2][0]), 32'(1'b1));
        chk("p07_nopar_stop_bit", 32'(rec_q[9*CPB+2][1]), 32'(1'b1));
        chk("p07_nopar_busy_cycles", 32'(count_rec(1, 46, 1'b0)), 32'(40));
        chk("p07_nopar_done_cycle40", 32'(rec_d[40][1]), 32'(1'b1));
        check_rx(0, 8'h07);
        check_rx(1, 8'h07);

        wait_idle();
        d     = 8'h3C;
        valid = 1'b1;
        @(posedge clk);
        #2 d = 8'hFF;
        record(50, 1'b0);
        valid = 1'b0;
        chk("b2b_busy_c44", 32'(rec_b[44][0]), 32'(1'b1));
        chk("b2b_idle_c45", 32'(rec_b[45][0]), 32'(1'b0));
        chk("b2b_start_c46", 32'(rec_q[46][0]), 32'(1'b0));
        chk("b2b_busy_c46", 32'(rec_b[46][0]), 32'(1'b1));
        chk("b2b_nopar_idle_c41", 32'(rec_b[41][1]), 32'(1'b0));
        chk("b2b_nopar_busy_c42", 32'(rec_b[42][1]), 32'(1'b1));
        wait_idle();
        check_rx(0, 8'h3C);
        check_rx(0, 8'hFF);
        check_rx(1, 8'h3C);
        check_rx(1, 8'hFF);

        start_frame(8'h55);
        repeat (14) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_q", 32'(q0), 32'(1'b1));
        chk("abort_busy", 32'(busy0), 32'(1'b0));
        chk("abort_done", 32'(done0), 32'(1'b0));
        chk("abort_ready", 32'(ready0), 32'(1'b1));
        chk("abort_nopar_q", 32'(q1), 32'(1'b1));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        d     = 8'h81;
        valid = 1'b1;
        @(posedge clk);
        #2 valid = 1'b0;
        @(negedge clk);
        chk("post_reset_first_accept_q", 32'(q0), 32'(1'b0));
        chk("post_reset_first_accept_busy", 32'(busy0), 32'(1'b1));
        wait_idle();
        check_rx(0, 8'h81);
        check_rx(1, 8'h81);

        start_frame(8'hC3);
        record(46, 1'b1);
        valid = 1'b0;
        d     = '0;
        chk("toggle_busy_cycles", 32'(count_rec(0, 46, 1'b0)), 32'(44));
        wait_idle();
        check_rx(0, 8'hC3);
        check_rx(1, 8'hC3);

        repeat (5) @(negedge clk);
        chk("total_done0", 32'(done_cnt[0]), 32'(6));
        chk("total_done1", 32'(done_cnt[1]), 32'(6));
        chk("total_rx0", 32'(rx_n[0]), 32'(6));
        chk("total_rx1", 32'(rx_n[1]), 32'(6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
